// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, WIDTH data bits (LSB- or MSB-first), optional parity, stop.
// Completed words go to a one-entry valid/ready buffer with parity, framing and overrun status.
module serial_frame_rx #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PARITY_EN  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             en,
  input  logic             mode,
  input  logic             dready,
  output logic [WIDTH-1:0] dout,
  output logic             dvalid,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  localparam int unsigned CntW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic        ParOdd = (PARITY_ODD != 0);
  localparam logic        ParEn  = (PARITY_EN != 0);

  typedef enum logic [1:0] {StIdle, StData, StPar, StStop} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              mode_q, mode_d;
  logic              par_q, par_d;
  logic              perr_q, perr_d;
  logic              complete;

  logic [WIDTH-1:0]  dout_q, dout_d;
  logic              dvalid_q, dvalid_d;
  logic              perr_out_q, perr_out_d;
  logic              ferr_q, ferr_d;
  logic              overrun_q, overrun_d;
  logic              busy_q, busy_d;
  logic              accept, drop;

  // Frame FSM and shifter; nothing moves on edges where en is low.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    par_d    = par_q;
    perr_d   = perr_q;
    complete = 1'b0;
    if (en) begin
      unique case (state_q)
        StIdle: begin
          if (!sin) begin
            state_d = StData;
            mode_d  = mode;
            cnt_d   = '0;
            par_d   = 1'b0;
            perr_d  = 1'b0;
          end
        end
        StData: begin
          par_d   = par_q ^ sin;
          shreg_d = mode_q ? {shreg_q[WIDTH-2:0], sin} : {sin, shreg_q[WIDTH-1:1]};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CntW'(WIDTH - 1)) begin
            state_d = ParEn ? StPar : StStop;
          end
        end
        StPar: begin
          perr_d  = par_q ^ sin ^ ParOdd;
          state_d = StStop;
        end
        StStop: begin
          complete = 1'b1;
          state_d  = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Output buffer: a completing frame loads if the slot is free or being emptied this edge.
  always_comb begin
    dout_d     = dout_q;
    dvalid_d   = dvalid_q;
    perr_out_d = perr_out_q;
    ferr_d     = ferr_q;
    overrun_d  = overrun_q;
    accept     = dvalid_q & dready;
    drop       = 1'b0;
    if (complete) begin
      if (!dvalid_q || dready) begin
        dout_d     = shreg_q;
        dvalid_d   = 1'b1;
        perr_out_d = ParEn & perr_q;
        ferr_d     = ~sin;
      end else begin
        drop = 1'b1;
      end
    end else if (accept) begin
      dvalid_d = 1'b0;
    end
    if (accept) overrun_d = 1'b0;
    if (drop)   overrun_d = 1'b1;
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      shreg_q    <= '0;
      cnt_q      <= '0;
      mode_q     <= 1'b0;
      par_q      <= 1'b0;
      perr_q     <= 1'b0;
      dout_q     <= '0;
      dvalid_q   <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_q     <= 1'b0;
      overrun_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      par_q      <= par_d;
      perr_q     <= perr_d;
      dout_q     <= dout_d;
      dvalid_q   <= dvalid_d;
      perr_out_q <= perr_out_d;
      ferr_q     <= ferr_d;
      overrun_q  <= overrun_d;
      busy_q     <= busy_d;
    end
  end

  assign dout       = dout_q;
  assign dvalid     = dvalid_q;
  assign parity_err = perr_out_q;
  assign frame_err  = ferr_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: directed scenarios then random frames, checked against a
// frame-level model (word from bit order, parity from XOR reduction, one-slot buffer).
module tb_serial_frame_rx;

  logic       clk;
  logic       rst;
  logic       sin;
  logic       en;
  logic       mode;
  logic       dready;
  logic [7:0] dout;
  logic       dvalid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int total = 0;
  int bad   = 0;

  logic [7:0] m_dout  = '0;
  logic       m_valid = 1'b0;
  logic       m_pe    = 1'b0;
  logic       m_fe    = 1'b0;
  logic       m_ov    = 1'b0;
  logic       m_busy  = 1'b0;
  bit         rdy_rand = 1'b0;

  serial_frame_rx #(
    .WIDTH     (8),
    .PARITY_EN (1),
    .PARITY_ODD(0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sin       (sin),
    .en        (en),
    .mode      (mode),
    .dready    (dready),
    .dout      (dout),
    .dvalid    (dvalid),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".dvalid"},  32'(dvalid),     32'(m_valid));
    check({tag, ".dout"},    32'(dout),       32'(m_dout));
    check({tag, ".perr"},    32'(parity_err), 32'(m_pe));
    check({tag, ".ferr"},    32'(frame_err),  32'(m_fe));
    check({tag, ".overrun"}, 32'(overrun),    32'(m_ov));
    check({tag, ".busy"},    32'(busy),       32'(m_busy));
  endtask

  // One clock; done marks the edge that samples a stop bit carrying word w.
  task automatic cyc(input bit done, input logic [7:0] w, input bit pe, input bit fe,
                     input bit busy_after);
    bit acc;
    bit drop;
    if (rdy_rand) dready = 1'($urandom);
    @(posedge clk);
    acc  = m_valid && dready;
    drop = 1'b0;
    if (done) begin
      if (!m_valid || dready) begin
        m_dout  = w;
        m_pe    = pe;
        m_fe    = fe;
        m_valid = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end else if (acc) begin
      m_valid = 1'b0;
    end
    if (acc)  m_ov = 1'b0;
    if (drop) m_ov = 1'b1;
    m_busy = busy_after;
    #1;
    check_all("cyc");
  endtask

  // db holds data bits in wire order: db[0] is sent first.
  task automatic send(input logic [7:0] db, input bit m, input bit bad_par, input bit bad_stop,
                      input bit tog);
    logic [7:0] w;
    bit         seq[$];
    bit         last;
    for (int i = 0; i < 8; i++) w[i] = m ? db[7-i] : db[i];
    seq.push_back(1'b0);
    for (int i = 0; i < 8; i++) seq.push_back(db[i]);
    seq.push_back((^db) ^ bad_par);
    seq.push_back(~bad_stop);
    mode = m;
    for (int i = 0; i < seq.size(); i++) begin
      sin  = seq[i];
      en   = 1'b1;
      last = (i == seq.size() - 1);
      cyc(last, w, bad_par, bad_stop, !last);
      if (i == 0) mode = 1'($urandom);
      if (tog) begin
        en  = 1'b0;
        sin = 1'($urandom);
        cyc(1'b0, w, 1'b0, 1'b0, !last);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      en  = 1'($urandom);
      sin = en ? 1'b1 : 1'($urandom);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    rst    = 1'b0;
    sin    = 1'b1;
    en     = 1'b0;
    mode   = 1'b0;
    dready = 1'b0;
    #2;
    check_all("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // LSB-first 0x1B, clean frame.
    dready = 1'b1;
    idle(2);
    send(8'h1B, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t1.dout_const", 32'(dout), 32'h1B);

    // Same wire bits, MSB-first.
    send(8'h1B, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t2.dout_const", 32'(dout), 32'hD8);

    send(8'h1B, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t3.perr_const", 32'(parity_err), 32'h1);
    send(8'h1B, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t4.ferr_const", 32'(frame_err), 32'h1);
    check("t4.busy_const", 32'(busy), 32'h0);

    // Overrun: buffer held, second frame dropped, one handshake clears it.
    idle(2);
    dready = 1'b0;
    send(8'h1B, 1'b0, 1'b0, 1'b0, 1'b0);
    send(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t5.dout_const", 32'(dout), 32'h1B);
    check("t5.ov_const", 32'(overrun), 32'h1);
    dready = 1'b1;
    en     = 1'b0;
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("t5.ov_clr_const", 32'(overrun), 32'h0);
    dready = 1'b0;
    send(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t5.dout2_const", 32'(dout), 32'h55);

    // en toggling every cycle.
    dready = 1'b1;
    idle(2);
    send(8'h1B, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t6.dout_const", 32'(dout), 32'h1B);

    // Reset after four data bits, then a clean frame.
    idle(2);
    mode = 1'b0;
    sin  = 1'b0;
    en   = 1'b1;
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      sin = 1'($urandom);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    end
    #2;
    rst     = 1'b0;
    #1;
    m_dout  = '0;
    m_valid = 1'b0;
    m_pe    = 1'b0;
    m_fe    = 1'b0;
    m_ov    = 1'b0;
    m_busy  = 1'b0;
    check_all("t7.rst");
    @(posedge clk);
    #1;
    rst = 1'b1;
    sin = 1'b1;
    idle(2);
    send(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t7.dout_const", 32'(dout), 32'hA5);

    // Random frames with random dready, en gaps and errors.
    rdy_rand = 1'b1;
    for (int f = 0; f < 40; f++) begin
      send(8'($urandom), 1'($urandom), ($urandom_range(3) == 0), ($urandom_range(3) == 0),
           1'($urandom));
      idle(int'($urandom_range(3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
- Downstream consumer of the 4-bit bidirectional serial shift register's `sout` stream.
- Frames the serial bitstream as start, WIDTH data bits, optional parity, stop.
- Assembles the word LSB-first or MSB-first, selected by mode, matching the shifter's direction.
- Presents each word through a one-entry valid/ready output buffer with parity, framing and overrun status.

Parameters:
- WIDTH, 8, number of data bits per frame (2..32).
- PARITY_EN, 1, 1 = a parity bit follows the data bits; 0 = no parity bit.
- PARITY_ODD, 0, 0 = even parity expected; 1 = odd parity expected.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- sin  input  1  serial data in (driven by upstream `sout`); idles high.
- en  input  1  bit-sample enable; sin is sampled only on edges where en=1.
- mode  input  1  0 = first data bit is LSB; 1 = first data bit is MSB. Latched at start bit.
- dready  input  1  consumer accepts dout this cycle.
- dout  output  WIDTH  assembled data word.
- dvalid  output  1  dout and status are valid.
- parity_err  output  1  parity mismatch for the word in dout.
- frame_err  output  1  stop bit sampled as 0 for the word in dout.
- overrun  output  1  sticky; a completed frame was dropped because the buffer was full.
- busy  output  1  high while the FSM is not in IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE.
  - dout=0, dvalid=0, parity_err=0, frame_err=0, overrun=0, busy=0.
  - Shift register, bit counter and latched mode are cleared.
- Reset mid-frame aborts the frame; no partial word is ever presented.
- FSM states: IDLE, DATA, PAR, STOP. All transitions occur only on edges where en=1; when en=0, all FSM and shift state holds.
- IDLE: sin=0 → latch mode, clear bit counter and running parity, go to DATA. sin=1 → stay in IDLE.
- DATA:
  - Each sampled bit is XORed into the running parity.
  - mode=0: the bit is shifted in at the MSB end, shifting right, so the first bit lands in bit 0.
  - mode=1: the bit is shifted in at bit 0, shifting left, so the first bit lands in bit WIDTH-1.
  - After WIDTH samples: go to PAR if PARITY_EN=1, else STOP.
- PAR: sample the parity bit. Error condition = (running parity XOR parity bit XOR PARITY_ODD) != 0. Go to STOP.
- STOP: sample the stop bit; frame error = (sin==0). Go to IDLE regardless of the stop value. No automatic resync beyond waiting for the next 0 in IDLE.
- Frame completion happens on the edge that samples the stop bit:
  - If buffer empty (dvalid=0), or dvalid=1 and dready=1 on that same edge: load dout, parity_err, frame_err; dvalid=1 on that edge (zero added latency).
  - Otherwise the frame is dropped: dout and flags are kept, overrun=1.
- Handshake:
  - dvalid=1 and dready=1 with no simultaneous completion → dvalid=0 on the next edge.
  - dout, parity_err and frame_err remain stable while dvalid=1.
  - Each accepted handshake clears overrun, unless a drop occurs on the same edge; a drop takes priority.
- busy = (state != IDLE), registered.
- Parity checking is disabled when PARITY_EN=0; parity_err is then always 0.
- Minimum frame length with en held high: 1 + WIDTH + PARITY_EN + 1 clocks.
- dvalid=1 does not stall reception; reception continues regardless of dready.

Test Plan:
- Reset, then en=1, mode=0, dready=1, WIDTH=8, even parity. Send sin bits 0, 1,1,0,1,1,0,0,0, 0, 1 (start, 0x1B LSB-first, parity 0, stop) → dvalid rises on the stop edge, dout=0x1B, parity_err=0, frame_err=0.
- Same bit sequence with mode=1 → dout=0xD8, flags 0.
- 0x1B frame with parity bit 1 → dout=0x1B, parity_err=1. 0x1B frame with stop bit 0 → frame_err=1, FSM back in IDLE.
- dready=0; send 0x1B then 0x55 → dout stays 0x1B, overrun=1. Raise dready for one cycle → dvalid=0, overrun=0. Next frame 0x55 → dout=0x55.
- Send 0x1B with en toggling 1,0 every cycle → same result as the first scenario, taking twice as many clocks; state holds on en=0 edges.
- Assert rst=0 for one cycle after 4 data bits → all outputs 0, busy=0. A subsequent full 0xA5 frame → dout=0xA5 with no corruption from the aborted frame.
